lsu: RTL and testbench

Load/store initiator that drives the single-cycle, word-addressed data memory on behalf of the CPU memory stage.
- Accepts one RISC-V load or store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW, selected by funct3.
- Converts byte addresses to word indices.
- Performs sub-word stores as read-modify-write.
- Sign- or zero-extends load data.
- Returns a single-cycle response.
- Guarantees the memory never sees read and write enables high together.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu.sv | 135 +++++++++++++
 tb/tb_lsu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings and FSM state type for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extract/extend and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  lane_shift;
  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_shift = {addr_lo, 3'b000};
  assign shifted    = rdata >> lane_shift;
  assign lane_b     = shifted[7:0];
  assign lane_h     = shifted[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_data = {24'h0, lane_b};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = rdata;
    endcase
  end

  // Clear the target lane in the old word, then OR in the shifted store data.
  always_comb begin
    store_data = wdata;
    case (funct3)
      F3_B: store_data = (old_word & ~(32'h0000_00FF << lane_shift))
                         | ({24'h0, wdata[7:0]} << lane_shift);
      F3_H: store_data = (old_word & ~(32'h0000_FFFF << lane_shift))
                         | ({16'h0, wdata[15:0]} << lane_shift);
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store initiator for a word-addressed data memory
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_word;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic        accept;
  logic        legal_f3, aligned, in_range, req_ok;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    legal_f3 = 1'b0;
    aligned  = 1'b1;
    if (req_we)
      legal_f3 = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      legal_f3 = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W)
              || (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    case (req_funct3)
      F3_H, F3_HU: aligned = (req_addr[0] == 1'b0);
      F3_W:        aligned = (req_addr[1:0] == 2'b00);
      default:     aligned = 1'b1;
    endcase
  end

  assign in_range = {2'b00, req_addr[31:2]} < MEM_WORDS;
  assign req_ok   = legal_f3 && aligned && in_range;

  lsu_align u_align (
    .rdata      (mem_rdata),
    .old_word   (old_word),
    .wdata      (wdata_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Full-word stores skip the read; sub-word stores read first to merge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_ok)                      state_next = RESP;
          else if (!req_we)                 state_next = READ;
          else if (req_funct3 == F3_W)      state_next = WRITE;
          else                              state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_rd_en  = (state == READ);
    mem_wr_en  = (state == WRITE) && !rst;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if (state == READ || state == WRITE) mem_addr = {2'b00, addr_q[31:2]};
    if (state == WRITE)                  mem_wdata = store_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      old_word   <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (!req_ok) begin
          resp_err   <= 1'b1;
          resp_rdata <= 32'h0;
        end
      end
      if (state == READ) begin
        old_word <= mem_rdata;
        if (!we_q) begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
        end
      end
      if (state == WRITE) begin
        resp_rdata <= 32'h0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu with a behavioural 32-word memory
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:31];

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_addr  [1:4];
  logic [31:0] obs_wdata [1:4];
  logic        obs_rd    [1:4];
  logic        obs_wr    [1:4];
  int          resp_cyc;
  int          resp_cnt;
  logic [31:0] resp_data;
  logic        resp_e;
  logic        both_en;
  logic        any_en;

  always #5 clk = ~clk;

  lsu #(.MEM_WORDS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_wr_en && mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one request, then records four cycles of memory-side activity and the response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    check("ready_at_accept", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    resp_cyc = 0; resp_cnt = 0; resp_data = 32'hX; resp_e = 1'bX;
    both_en = 1'b0; any_en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      obs_addr[c]  = mem_addr;
      obs_wdata[c] = mem_wdata;
      obs_rd[c]    = mem_rd_en;
      obs_wr[c]    = mem_wr_en;
      if (mem_rd_en && mem_wr_en) both_en = 1'b1;
      if (mem_rd_en || mem_wr_en) any_en = 1'b1;
      if (resp_valid) begin
        resp_cnt++;
        if (resp_cyc == 0) begin
          resp_cyc  = c;
          resp_data = resp_rdata;
          resp_e    = resp_err;
        end
      end
      if (c < 4) @(negedge clk);
    end
    check("no_rd_wr_overlap", {31'h0, both_en}, 32'h0);
    check("single_resp_pulse", resp_cnt, 1);
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic err,
                             input logic [31:0] data);
    check({tag, "_lat"},  resp_cyc, lat);
    check({tag, "_err"},  {31'h0, resp_e}, {31'h0, err});
    check({tag, "_data"}, resp_data, data);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and quiet idle
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("idle_quiet", {29'h0, resp_valid, mem_rd_en, mem_wr_en}, 32'h0);
      @(negedge clk);
    end

    // SW then LW
    issue(1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
    expect_resp("sw08", 2, 1'b0, 32'h0);
    check("sw08_wr_c1", {30'h0, obs_rd[1], obs_wr[1]}, 32'h1);
    check("sw08_addr_c1", obs_addr[1], 32'd2);
    check("sw08_wdata_c1", obs_wdata[1], 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h08, 32'h0);
    expect_resp("lw08", 2, 1'b0, 32'hDEADBEEF);
    check("lw08_rd_c1", {30'h0, obs_rd[1], obs_wr[1]}, 32'h2);

    // SB read-modify-write then LB/LBU
    issue(1'b1, 3'd0, 32'h09, 32'h000000AA);
    expect_resp("sb09", 3, 1'b0, 32'h0);
    check("sb09_rd_c1", {30'h0, obs_rd[1], obs_wr[1]}, 32'h2);
    check("sb09_addr_c1", obs_addr[1], 32'd2);
    check("sb09_wr_c2", {30'h0, obs_rd[2], obs_wr[2]}, 32'h1);
    check("sb09_wdata_c2", obs_wdata[2], 32'hDEADAAEF);
    issue(1'b0, 3'd0, 32'h09, 32'h0);
    expect_resp("lb09", 2, 1'b0, 32'hFFFFFFAA);
    issue(1'b0, 3'd4, 32'h09, 32'h0);
    expect_resp("lbu09", 2, 1'b0, 32'h000000AA);

    // SH upper half, halfword loads and a misaligned LH
    issue(1'b1, 3'd1, 32'h0A, 32'h00001234);
    expect_resp("sh0a", 3, 1'b0, 32'h0);
    check("sh0a_wdata_c2", obs_wdata[2], 32'h1234AAEF);
    issue(1'b0, 3'd1, 32'h0A, 32'h0);
    expect_resp("lh0a", 2, 1'b0, 32'h00001234);
    issue(1'b0, 3'd1, 32'h08, 32'h0);
    expect_resp("lh08", 2, 1'b0, 32'hFFFFAAEF);
    issue(1'b0, 3'd5, 32'h08, 32'h0);
    expect_resp("lhu08", 2, 1'b0, 32'h0000AAEF);
    issue(1'b0, 3'd1, 32'h0B, 32'h0);
    expect_resp("lh0b_misal", 1, 1'b1, 32'h0);
    check("lh0b_no_enable", {31'h0, any_en}, 32'h0);

    // Range boundary and illegal funct3
    issue(1'b0, 3'd2, 32'h80, 32'h0);
    expect_resp("lw80_range", 1, 1'b1, 32'h0);
    check("lw80_no_enable", {31'h0, any_en}, 32'h0);
    issue(1'b1, 3'd2, 32'h7C, 32'h5);
    expect_resp("sw7c", 2, 1'b0, 32'h0);
    check("sw7c_addr_c1", obs_addr[1], 32'd31);
    issue(1'b0, 3'd2, 32'h7C, 32'h0);
    expect_resp("lw7c", 2, 1'b0, 32'h5);
    issue(1'b0, 3'd3, 32'h10, 32'h0);
    expect_resp("load_f3_3", 1, 1'b1, 32'h0);
    issue(1'b1, 3'd4, 32'h10, 32'h0);
    expect_resp("store_f3_4", 1, 1'b1, 32'h0);
    check("store_f3_4_no_enable", {31'h0, any_en}, 32'h0);

    // Reset during the WRITE cycle of an SB suppresses the commit
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h08; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_read_c1", {30'h0, mem_rd_en, mem_wr_en}, 32'h2);
    @(negedge clk);
    check("rstw_write_c2", {30'h0, mem_rd_en, mem_wr_en}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstw_wr_gated", {31'h0, mem_wr_en}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_ready_after", {31'h0, req_ready}, 32'h1);
    check("rstw_no_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    check("rstw_no_resp_late", {31'h0, resp_valid}, 32'h0);
    issue(1'b0, 3'd2, 32'h08, 32'h0);
    expect_resp("rstw_lw08", 2, 1'b0, 32'h1234AAEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
